// File: rtl/rob_retire_pkg.sv
// Shared constants and structs for the reorder-buffer retire block.
// No logic here, so no latency.
// No backpressure here; flow control lives in rob_retire (alloc_rdy).
package rob_retire_pkg;

    localparam int ROB_MAX_RETIRE = 4;   // retire lanes per cycle
    localparam int ROB_TAG_LEN    = 4;   // tag width; covers ROB_DEPTH up to 16
    localparam int SRC_LEN        = 5;   // architectural register index width
    localparam int DATA_LEN       = 32;  // result width

    // One retire lane as seen by the register-file writer.
    typedef struct packed {
        logic                v;
        logic                rfWrite;
        logic [SRC_LEN-1:0]  rd;
        logic [DATA_LEN-1:0] data;
    } info_ret_t;

    // One ROB slot.
    typedef struct packed {
        logic                alloc;
        logic                done;
        logic                rfWrite;
        logic [SRC_LEN-1:0]  rd;
        logic [DATA_LEN-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_if.sv
// Allocation, completion and retire bundle between the pipeline and the ROB.
// Pure wiring, no latency.
// Allocation is throttled by alloc_rdy; completion and retire are never stalled.
interface rob_retire_if
    import rob_retire_pkg::*;
#(
    parameter int RET_W = ROB_MAX_RETIRE
);

`ifdef ROB_FLUSH_EN
    logic                         flush;
`endif
    logic                         alloc_v;
    logic [SRC_LEN-1:0]           alloc_rd;
    logic                         alloc_rfWrite;
    logic                         alloc_rdy;
    logic [ROB_TAG_LEN-1:0]       alloc_tag;
    logic                         cmpl_v;
    logic [ROB_TAG_LEN-1:0]       cmpl_tag;
    logic [DATA_LEN-1:0]          cmpl_data;
    info_ret_t [RET_W-1:0]        info_ret;
    logic [ROB_TAG_LEN:0]         rob_count;

    // Pipeline side: issues allocations and completions, consumes retires.
    modport master (
`ifdef ROB_FLUSH_EN
        output flush,
`endif
        output alloc_v, alloc_rd, alloc_rfWrite,
        output cmpl_v, cmpl_tag, cmpl_data,
        input  alloc_rdy, alloc_tag, info_ret, rob_count
    );

    // ROB side.
    modport slave (
`ifdef ROB_FLUSH_EN
        input  flush,
`endif
        input  alloc_v, alloc_rd, alloc_rfWrite,
        input  cmpl_v, cmpl_tag, cmpl_data,
        output alloc_rdy, alloc_tag, info_ret, rob_count
    );

endinterface

// File: rtl/rob_ret_sel.sv
// Counts the run of consecutive done entries starting at the ROB head.
// Purely combinational, zero latency.
// No backpressure; the caller retires exactly k entries.
module rob_ret_sel #(
    parameter int RET_W = 4,
    parameter int KW    = $clog2(RET_W + 1)
) (
    input  logic [RET_W-1:0] done_rot,   // bit 0 = head entry
    output logic [KW-1:0]    k
);

    logic run;

    // The first not-done lane ends the run; younger done entries must wait.
    always_comb begin
        k   = '0;
        run = 1'b1;
        for (int i = 0; i < RET_W; i++) begin
            if (run && done_rot[i]) begin
                k = KW'(i + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_retire.sv
// In-order reorder buffer: allocate at tail, complete by tag, retire up to RET_W from head.
// Retire bundle is registered: 1 clock from a done entry being visible to info_ret.
// alloc_rdy drops when full (start-of-cycle count); optional flush via ROB_FLUSH_EN.
module rob_retire
    import rob_retire_pkg::*;
#(
    parameter int ROB_DEPTH = 16,             // power of two, >= 2, <= 2**ROB_TAG_LEN
    parameter int RET_W     = ROB_MAX_RETIRE  // <= ROB_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    rob_retire_if.slave   rif
);

    localparam int PTR_W = $clog2(ROB_DEPTH);
    localparam int KW    = $clog2(RET_W + 1);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(ROB_DEPTH);

    rob_entry_t        ent [ROB_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;

    logic [PTR_W-1:0]  ret_idx [RET_W];
    logic [RET_W-1:0]  done_rot;
    logic [KW-1:0]     k;

    logic              clr;
    logic              alloc_rdy;
    logic              alloc_acc;
    logic [PTR_W-1:0]  cmpl_idx;
    logic              cmpl_hit;

`ifdef ROB_FLUSH_EN
    assign clr = rst | rif.flush;
`else
    assign clr = rst;
`endif

    // Readiness uses only the start-of-cycle count, so a same-cycle retire never frees a slot early.
    assign alloc_rdy     = count < DEPTH_C;
    assign alloc_acc     = rif.alloc_v && alloc_rdy;
    assign rif.alloc_rdy = alloc_rdy;
    assign rif.alloc_tag = ROB_TAG_LEN'(tail);
    assign rif.rob_count = (ROB_TAG_LEN + 1)'(count);

    // Completions to out-of-range or unallocated tags are dropped.
    assign cmpl_idx = rif.cmpl_tag[PTR_W-1:0];
    assign cmpl_hit = rif.cmpl_v && ((rif.cmpl_tag >> PTR_W) == '0) && ent[cmpl_idx].alloc;

    // Present the done bits in age order starting at head; pointer arithmetic wraps naturally.
    always_comb begin
        for (int i = 0; i < RET_W; i++) begin
            ret_idx[i]  = head + PTR_W'(i);
            done_rot[i] = ent[ret_idx[i]].alloc && ent[ret_idx[i]].done;
        end
    end

    rob_ret_sel #(
        .RET_W (RET_W),
        .KW    (KW)
    ) u_sel (
        .done_rot (done_rot),
        .k        (k)
    );

    // Storage, pointers and the registered retire bundle; clear wins over all traffic.
    // Completion can't hit a retiring entry (it is already done) nor the tail (unallocated).
    always_ff @(posedge clk) begin
        if (clr) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rif.info_ret <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (cmpl_hit) begin
                ent[cmpl_idx].done <= 1'b1;
                ent[cmpl_idx].data <= rif.cmpl_data;
            end
            for (int i = 0; i < RET_W; i++) begin
                if (KW'(i) < k) begin
                    ent[ret_idx[i]].alloc    <= 1'b0;
                    ent[ret_idx[i]].done     <= 1'b0;
                    rif.info_ret[i].v        <= 1'b1;
                    rif.info_ret[i].rfWrite  <= ent[ret_idx[i]].rfWrite;
                    rif.info_ret[i].rd       <= ent[ret_idx[i]].rd;
                    rif.info_ret[i].data     <= ent[ret_idx[i]].data;
                end else begin
                    rif.info_ret[i] <= '0;
                end
            end
            if (alloc_acc) begin
                ent[tail].alloc   <= 1'b1;
                ent[tail].done    <= 1'b0;
                ent[tail].rfWrite <= rif.alloc_rfWrite;
                ent[tail].rd      <= rif.alloc_rd;
                ent[tail].data    <= '0;
                tail              <= tail + PTR_W'(1);
            end
            head  <= head + PTR_W'(k);
            count <= count + (PTR_W + 1)'(alloc_acc) - (PTR_W + 1)'(k);
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Default build (no flush port driven unless ROB_FLUSH_EN is defined).
module tb_rob_retire;
    import rob_retire_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rob_retire_if #(.RET_W(4)) rif ();

    rob_retire #(
        .ROB_DEPTH (16),
        .RET_W     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rif (rif)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic info_ret_t lane(input logic v, input logic rfw,
                                       input logic [4:0] rd, input logic [31:0] d);
        info_ret_t l;
        l.v       = v;
        l.rfWrite = rfw;
        l.rd      = rd;
        l.data    = d;
        return l;
    endfunction

    task automatic check_lane(input string tag, input int ln, input info_ret_t exp);
        check(tag, 64'(rif.info_ret[ln]), 64'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic rfw);
        rif.alloc_v       = 1'b1;
        rif.alloc_rd      = rd;
        rif.alloc_rfWrite = rfw;
        step();
        rif.alloc_v       = 1'b0;
    endtask

    task automatic do_cmpl(input logic [3:0] tag, input logic [31:0] d);
        rif.cmpl_v    = 1'b1;
        rif.cmpl_tag  = tag;
        rif.cmpl_data = d;
        step();
        rif.cmpl_v    = 1'b0;
    endtask

    initial begin
`ifdef ROB_FLUSH_EN
        rif.flush         = 1'b0;
`endif
        rif.alloc_v       = 1'b0;
        rif.alloc_rd      = '0;
        rif.alloc_rfWrite = 1'b0;
        rif.cmpl_v        = 1'b0;
        rif.cmpl_tag      = '0;
        rif.cmpl_data     = '0;

        // Reset state
        do_reset();
        check("rst_count", 64'(rif.rob_count), 64'd0);
        check("rst_rdy",   64'(rif.alloc_rdy), 64'd1);
        check("rst_tag",   64'(rif.alloc_tag), 64'd0);
        for (int i = 0; i < 4; i++) check_lane("rst_lane", i, lane(0, 0, 0, 0));

        // Three allocations, completed youngest first so all retire together
        check("t1_tag0", 64'(rif.alloc_tag), 64'd0);
        do_alloc(5'd5, 1'b1);
        do_alloc(5'd6, 1'b1);
        do_alloc(5'd7, 1'b1);
        check("t1_count3", 64'(rif.rob_count), 64'd3);
        do_cmpl(4'd2, 32'hC);
        do_cmpl(4'd1, 32'hB);
        do_cmpl(4'd0, 32'hA);
        check_lane("t1_not_yet", 0, lane(0, 0, 0, 0));
        step();
        check_lane("t1_lane0", 0, lane(1, 1, 5'd5, 32'hA));
        check_lane("t1_lane1", 1, lane(1, 1, 5'd6, 32'hB));
        check_lane("t1_lane2", 2, lane(1, 1, 5'd7, 32'hC));
        check_lane("t1_lane3", 3, lane(0, 0, 0, 0));
        check("t1_count0", 64'(rif.rob_count), 64'd0);
        step();
        check_lane("t1_idle", 0, lane(0, 0, 0, 0));

        // Out-of-order completion held back by an incomplete head
        do_reset();
        do_alloc(5'd1, 1'b1);
        do_alloc(5'd2, 1'b1);
        do_cmpl(4'd1, 32'h11);
        step();
        check_lane("t2_blocked", 0, lane(0, 0, 0, 0));
        check("t2_count2", 64'(rif.rob_count), 64'd2);
        do_cmpl(4'd0, 32'h10);
        step();
        check_lane("t2_lane0", 0, lane(1, 1, 5'd1, 32'h10));
        check_lane("t2_lane1", 1, lane(1, 1, 5'd2, 32'h11));
        check_lane("t2_lane2", 2, lane(0, 0, 0, 0));
        check("t2_count0", 64'(rif.rob_count), 64'd0);

        // Full ROB: further allocation ignored; freed slot accepted one cycle later
        do_reset();
        for (int i = 0; i < 16; i++) do_alloc(5'(i), 1'b1);
        check("t3_full_count", 64'(rif.rob_count), 64'd16);
        check("t3_full_rdy",   64'(rif.alloc_rdy), 64'd0);
        rif.alloc_v       = 1'b1;
        rif.alloc_rd      = 5'd31;
        rif.alloc_rfWrite = 1'b1;
        step();
        check("t3_ignored", 64'(rif.rob_count), 64'd16);
        rif.cmpl_v    = 1'b1;
        rif.cmpl_tag  = 4'd0;
        rif.cmpl_data = 32'h55;
        step();
        rif.cmpl_v    = 1'b0;
        check("t3_still_full", 64'(rif.rob_count), 64'd16);
        step();
        check_lane("t3_ret0", 0, lane(1, 1, 5'd0, 32'h55));
        check("t3_count15", 64'(rif.rob_count), 64'd15);
        check("t3_rdy",     64'(rif.alloc_rdy), 64'd1);
        check("t3_wraptag", 64'(rif.alloc_tag), 64'd0);
        step();
        rif.alloc_v = 1'b0;
        check("t3_accepted", 64'(rif.rob_count), 64'd16);
        check("t3_tag1",     64'(rif.alloc_tag), 64'd1);

        // Move head to 14, then retire a run crossing 15 -> 0 (rd=0 and duplicate rd pass through)
        do_reset();
        for (int i = 0; i < 14; i++) begin
            do_alloc(5'(i), 1'b1);
            do_cmpl(4'(i), 32'(i));
        end
        step();
        step();
        check("t4_drained", 64'(rif.rob_count), 64'd0);
        check("t4_tag14",   64'(rif.alloc_tag), 64'd14);
        do_alloc(5'd0,  1'b1);
        do_alloc(5'd0,  1'b1);
        do_alloc(5'd22, 1'b0);
        do_alloc(5'd23, 1'b1);
        check("t4_count4", 64'(rif.rob_count), 64'd4);
        do_cmpl(4'd1,  32'h101);
        do_cmpl(4'd0,  32'h100);
        do_cmpl(4'd15, 32'h10F);
        check_lane("t4_blocked", 0, lane(0, 0, 0, 0));
        do_cmpl(4'd14, 32'h10E);
        check_lane("t4_no_bypass", 0, lane(0, 0, 0, 0));
        step();
        check_lane("t4_lane0", 0, lane(1, 1, 5'd0,  32'h10E));
        check_lane("t4_lane1", 1, lane(1, 1, 5'd0,  32'h10F));
        check_lane("t4_lane2", 2, lane(1, 0, 5'd22, 32'h100));
        check_lane("t4_lane3", 3, lane(1, 1, 5'd23, 32'h101));
        check("t4_count0", 64'(rif.rob_count), 64'd0);

        // Completion to unallocated tag 9 is dropped; later allocation of tag 9 starts not done
        do_cmpl(4'd9, 32'hDEAD);
        step();
        check("t5_count0", 64'(rif.rob_count), 64'd0);
        check_lane("t5_noret", 0, lane(0, 0, 0, 0));
        for (int t = 2; t < 10; t++) do_alloc(5'(t), 1'b1);
        check("t5_count8", 64'(rif.rob_count), 64'd8);
        check("t5_tag10",  64'(rif.alloc_tag), 64'd10);
        for (int t = 2; t < 9; t++) do_cmpl(4'(t), 32'h20 + 32'(t));
        step();
        step();
        step();
        check("t5_tag9_pending", 64'(rif.rob_count), 64'd1);
        check_lane("t5_quiet", 0, lane(0, 0, 0, 0));
        do_cmpl(4'd9, 32'h99);
        step();
        check_lane("t5_tag9", 0, lane(1, 1, 5'd9, 32'h99));
        check("t5_count0b", 64'(rif.rob_count), 64'd0);

        // Reset with five live entries, a pending retire, and alloc/cmpl active
        for (int i = 0; i < 5; i++) do_alloc(5'(20 + i), 1'b1);
        check("t6_count5", 64'(rif.rob_count), 64'd5);
        do_cmpl(4'd10, 32'h77);
        rst               = 1'b1;
        rif.cmpl_v        = 1'b1;
        rif.cmpl_tag      = 4'd11;
        rif.cmpl_data     = 32'h88;
        rif.alloc_v       = 1'b1;
        rif.alloc_rd      = 5'd3;
        rif.alloc_rfWrite = 1'b1;
        step();
        rst         = 1'b0;
        rif.cmpl_v  = 1'b0;
        rif.alloc_v = 1'b0;
        check("t6_count", 64'(rif.rob_count), 64'd0);
        check("t6_rdy",   64'(rif.alloc_rdy), 64'd1);
        check("t6_tag",   64'(rif.alloc_tag), 64'd0);
        for (int i = 0; i < 4; i++) check_lane("t6_lane", i, lane(0, 0, 0, 0));
        step();
        check("t6_count_after", 64'(rif.rob_count), 64'd0);
        check_lane("t6_lane_after", 0, lane(0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
